// File: rtl/swap_demux.sv
`default_nettype none
// ============================================================================
// Module   : swap_demux
// Brief    : Clocked four-phase 1-to-2 demultiplexer steered by a one-hot
//            control channel (ctl_a -> output 0, ctl_b -> output 1).
//            Optional macro SWAP_DEMUX_SYNC_EN adds 2-flop input synchronizers.
// Revision : 1.0 - initial release
// ============================================================================
module swap_demux #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         r_i,
    output logic         a_i,
    input  logic [N-1:0] d_i,
    input  logic         ctl_a,
    input  logic         ctl_b,
    output logic         actl_i,
    output logic         r0_o,
    input  logic         a0_o,
    output logic [N-1:0] d0_o,
    output logic         r1_o,
    input  logic         a1_o,
    output logic [N-1:0] d1_o,
    output logic         err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        ACK  = 2'd2,
        RTZ  = 2'd3
    } state_t;

    localparam int c_NSYNC = 5;

    logic [c_NSYNC-1:0] w_raw;
    logic [c_NSYNC-1:0] w_in;

    assign w_raw = {a1_o, a0_o, ctl_b, ctl_a, r_i};

`ifdef SWAP_DEMUX_SYNC_EN
    logic [c_NSYNC-1:0] r_meta;
    logic [c_NSYNC-1:0] r_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= w_raw;
            r_sync <= r_meta;
        end
    end

    assign w_in = r_sync;
`else
    assign w_in = w_raw;
`endif

    logic w_req;
    logic w_ca;
    logic w_cb;
    logic w_sel_ack;

    state_t       r_state;
    logic         r_sel;
    logic [N-1:0] r_d;
    logic         r_r0;
    logic         r_r1;
    logic         r_ack;
    logic         r_err;

    assign w_req     = w_in[0];
    assign w_ca      = w_in[1];
    assign w_cb      = w_in[2];
    // The unselected channel's acknowledge never reaches the FSM.
    assign w_sel_ack = r_sel ? w_in[4] : w_in[3];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_sel   <= 1'b0;
            r_d     <= '0;
            r_r0    <= 1'b0;
            r_r1    <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_ca && w_cb) begin
                        r_err <= 1'b1;
                    end else if (w_req && (w_ca || w_cb)) begin
                        r_d     <= d_i;
                        r_sel   <= w_cb;
                        r_r0    <= w_ca;
                        r_r1    <= w_cb;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (w_sel_ack) begin
                        r_ack   <= 1'b1;
                        r_state <= ACK;
                    end
                end
                ACK: begin
                    if (!w_req && !w_ca && !w_cb) begin
                        r_r0    <= 1'b0;
                        r_r1    <= 1'b0;
                        r_state <= RTZ;
                    end
                end
                RTZ: begin
                    if (!w_sel_ack) begin
                        r_ack   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign a_i    = r_ack;
    assign actl_i = r_ack;
    assign r0_o   = r_r0;
    assign r1_o   = r_r1;
    assign d0_o   = r_d;
    assign d1_o   = r_d;
    assign err_o  = r_err;

endmodule
`default_nettype wire
